// File: rtl/reg_writeback_queue.sv
// In-order writeback queue feeding the register file write port, with a
// combinational hazard/forwarding lookup over every write not yet committed.
module reg_writeback_queue #(
    parameter int unsigned REG_NUM  = 32,
    parameter int unsigned REG_SIZE = 32,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [$clog2(REG_NUM)-1:0] in_rd,
    input  logic [REG_SIZE-1:0]        in_data,
    output logic [$clog2(REG_NUM)-1:0] write_reg,
    output logic [REG_SIZE-1:0]        write_data,
    output logic                       reg_write,
    input  logic [$clog2(REG_NUM)-1:0] chk_reg_1,
    input  logic [$clog2(REG_NUM)-1:0] chk_reg_2,
    output logic                       chk_hit_1,
    output logic                       chk_hit_2,
    output logic [REG_SIZE-1:0]        fwd_data_1,
    output logic [REG_SIZE-1:0]        fwd_data_2,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(REG_NUM);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0]       rd_mem_q   [DEPTH];
    logic [REG_SIZE-1:0] data_mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q, count_d;
    logic                reg_write_q;
    logic [AW-1:0]       write_reg_q;
    logic [REG_SIZE-1:0] write_data_q;
    logic                push, pop;

    assign in_ready = (count_q != CW'(DEPTH));
    // Writes to x0 are accepted but never enter the queue.
    assign push     = in_valid && in_ready && (in_rd != '0);
    assign pop      = (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            count_q     <= count_d;
            reg_write_q <= pop;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                write_reg_q  <= rd_mem_q[rd_ptr_q];
                write_data_q <= data_mem_q[rd_ptr_q];
                rd_ptr_q     <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset; validity is tracked by count_q and the pointers.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            rd_mem_q[wr_ptr_q]   <= in_rd;
            data_mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Scan oldest to youngest so the youngest match wins; output stage is older than all.
    function automatic logic [REG_SIZE:0] lookup(input logic [AW-1:0] chk);
        logic                hit;
        logic [REG_SIZE-1:0] data;
        logic [PW-1:0]       idx;
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        if (chk != '0) begin
            if (reg_write_q && (write_reg_q == chk)) begin
                hit  = 1'b1;
                data = write_data_q;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                idx = rd_ptr_q + PW'(i);
                if ((CW'(i) < count_q) && (rd_mem_q[idx] == chk)) begin
                    hit  = 1'b1;
                    data = data_mem_q[idx];
                end
            end
        end
        return {hit, data};
    endfunction

    assign {chk_hit_1, fwd_data_1} = lookup(chk_reg_1);
    assign {chk_hit_2, fwd_data_2} = lookup(chk_reg_2);

    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;
    assign reg_write  = reg_write_q;
    assign count      = count_q;
    assign empty      = (count_q == '0) && !reg_write_q;

endmodule
